// File: rtl/pwm_sched_pkg.sv
// Shared types and constants for the double-buffered PWM output scheduler.
package pwm_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] DUTY_FULL = 8'hFF;

  // Full-scale duty is forced high so the last counter step never dips low.
  function automatic logic pwm_level(input logic [PWM_W-1:0] cnt,
                                     input logic [PWM_W-1:0] duty_val);
    return (duty_val == DUTY_FULL) || (cnt < duty_val);
  endfunction

endpackage

// File: rtl/pwm_sched_ctrl_timebase.sv
// Prescaler plus 8-bit PWM step counter; both are held at zero while clear is high.
module pwm_timebase
  import pwm_sched_pkg::*;
#(
  parameter int CLK_DIV = 3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             boundary,
  output logic [PWM_W-1:0] pwm_cnt
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PWM_W-1:0] CNT_LAST = {PWM_W{1'b1}};

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick     = !clear && (pre_cnt == PRE_LAST);
  assign boundary = tick && (pwm_cnt == CNT_LAST);

  // pwm_cnt wraps naturally from 255 to 0 on the boundary tick.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/pwm_sched_ctrl.sv
// Drives N_OUT outputs as static or PWM from shadowed SPI configuration,
// applying new configuration only from idle or at a PWM period boundary.
module pwm_sched_ctrl
  import pwm_sched_pkg::*;
#(
  parameter int CLK_DIV = 3000,
  parameter int N_OUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_OUT-1:0] en_out,
  input  logic [N_OUT-1:0] en_pwm,
  input  logic [PWM_W-1:0] duty,
  input  logic             cfg_update,
  output logic [N_OUT-1:0] out,
  output logic             period_start,
  output logic             cfg_pending,
  output logic             running
);

  state_t           state, state_nxt;
  logic             load_sh;
  logic             pending_nxt;
  logic             boundary;
  logic             lvl;
  logic [PWM_W-1:0] pwm_cnt;
  logic [N_OUT-1:0] en_out_sh;
  logic [N_OUT-1:0] en_pwm_sh;
  logic [PWM_W-1:0] duty_sh;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .boundary (boundary),
    .pwm_cnt  (pwm_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cfg_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      cfg_pending <= pending_nxt;
    end
  end

  // An update arriving on the boundary cycle itself is applied at once rather than pended.
  always_comb begin
    state_nxt   = state;
    load_sh     = 1'b0;
    pending_nxt = cfg_pending;
    case (state)
      IDLE: begin
        pending_nxt = 1'b0;
        if (cfg_update) begin
          load_sh = 1'b1;
          if (en_out != '0) state_nxt = RUN;
        end
      end
      RUN: begin
        if (boundary && (cfg_pending || cfg_update)) begin
          load_sh     = 1'b1;
          pending_nxt = 1'b0;
          if (en_out == '0) state_nxt = IDLE;
        end else if (cfg_update) begin
          pending_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_out_sh <= '0;
      en_pwm_sh <= '0;
      duty_sh   <= '0;
    end else if (load_sh) begin
      en_out_sh <= en_out;
      en_pwm_sh <= en_pwm;
      duty_sh   <= duty;
    end
  end

  assign lvl = pwm_level(pwm_cnt, duty_sh);

  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= (state == RUN) ? (en_out_sh & (~en_pwm_sh | {N_OUT{lvl}})) : '0;
      period_start <= (state == RUN) && boundary;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_pwm_sched_ctrl.sv
// Randomized scoreboard bench: a cycle-time reference model predicts every
// registered output, and a monitor compares them one cycle at a time.
module tb_pwm_sched_ctrl;

  localparam int CLK_DIV = 2;
  localparam int N_OUT   = 16;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_OUT-1:0] en_out;
  logic [N_OUT-1:0] en_pwm;
  logic [7:0]       duty;
  logic             cfg_update;
  logic [N_OUT-1:0] out;
  logic             period_start;
  logic             cfg_pending;
  logic             running;

  pwm_sched_ctrl #(
    .CLK_DIV (CLK_DIV),
    .N_OUT   (N_OUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty         (duty),
    .cfg_update   (cfg_update),
    .out          (out),
    .period_start (period_start),
    .cfg_pending  (cfg_pending),
    .running      (running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_OUT-1:0] out;
    logic             ps;
    logic             pend;
    logic             run;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;

  // Reference model: phase counts clk cycles since the current period began.
  bit               m_run, m_pend, m_ps;
  logic [N_OUT-1:0] m_sh_en, m_sh_pwm, m_out;
  logic [7:0]       m_sh_duty;
  int               m_phase;

  task automatic model_step(input bit r, input logic [N_OUT-1:0] eo,
                            input logic [N_OUT-1:0] ep, input logic [7:0] d,
                            input bit u);
    bit lvl, bnd;
    int step;
    exp_t e;
    if (r) begin
      m_run = 0; m_pend = 0; m_ps = 0; m_phase = 0;
      m_sh_en = '0; m_sh_pwm = '0; m_sh_duty = '0; m_out = '0;
    end else begin
      step  = m_phase / CLK_DIV;
      lvl   = (m_sh_duty == 8'hFF) || (step < int'(m_sh_duty));
      m_out = '0;
      if (m_run)
        for (int i = 0; i < N_OUT; i++)
          m_out[i] = m_sh_en[i] && (m_sh_pwm[i] ? lvl : 1'b1);
      if (!m_run) begin
        m_ps = 0;
        m_phase = 0;
        if (u) begin
          m_sh_en = eo; m_sh_pwm = ep; m_sh_duty = d;
          m_run = (eo != '0);
        end
      end else begin
        bnd     = (m_phase == PERIOD - 1);
        m_ps    = bnd;
        m_phase = bnd ? 0 : m_phase + 1;
        if (bnd && (m_pend || u)) begin
          m_sh_en = eo; m_sh_pwm = ep; m_sh_duty = d;
          m_pend = 0;
          m_run  = (eo != '0);
          m_phase = 0;
        end else if (u) begin
          m_pend = 1;
        end
      end
    end
    e.out  = m_out;
    e.ps   = m_ps;
    e.pend = m_pend;
    e.run  = m_run;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit r, input logic [N_OUT-1:0] eo,
                                input logic [N_OUT-1:0] ep, input logic [7:0] d,
                                input bit u);
    rst        = r;
    en_out     = eo;
    en_pwm     = ep;
    duty       = d;
    cfg_update = u;
    model_step(r, eo, ep, d, u);
    @(posedge clk);
    #1;
  endtask

  // Live inputs wander without cfg_update; the design must ignore them.
  task automatic noise_cycles(input int n);
    for (int i = 0; i < n; i++)
      apply_stimulus(1'b0, N_OUT'($urandom), N_OUT'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic wait_phase(input int target);
    for (int i = 0; i < 2 * PERIOD && m_run && m_phase != target; i++)
      noise_cycles(1);
  endtask

  task automatic check_output(input exp_t e);
    exp_t got;
    got.out  = out;
    got.ps   = period_start;
    got.pend = cfg_pending;
    got.run  = running;
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL cycle %0d: got out=%h ps=%b pend=%b run=%b, expected out=%h ps=%b pend=%b run=%b",
               cycle, got.out, got.ps, got.pend, got.run, e.out, e.ps, e.pend, e.run);
    end
  endtask

  always @(posedge clk) begin
    #2;
    cycle++;
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  initial begin
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, N_OUT'($urandom), N_OUT'($urandom), 8'($urandom), 1'b0);

    // Static-high single output from idle.
    apply_stimulus(1'b0, 16'h0001, 16'h0000, 8'h00, 1'b1);
    noise_cycles(600);

    // Disable, then half-duty PWM on the low byte.
    apply_stimulus(1'b0, 16'h0000, N_OUT'($urandom), 8'($urandom), 1'b1);
    noise_cycles(PERIOD + 10);
    apply_stimulus(1'b0, 16'h00FF, 16'h00FF, 8'h80, 1'b1);
    noise_cycles(2 * PERIOD + 20);

    // Full and zero duty extremes.
    apply_stimulus(1'b0, 16'h00FF, 16'h00FF, 8'hFF, 1'b1);
    noise_cycles(4 * PERIOD);
    apply_stimulus(1'b0, 16'h00FF, 16'h00FF, 8'h00, 1'b1);
    noise_cycles(4 * PERIOD);

    // Two coalesced mid-period updates; the later duty wins.
    wait_phase(200);
    apply_stimulus(1'b0, 16'h00FF, 16'h00FF, 8'h40, 1'b1);
    noise_cycles(50);
    apply_stimulus(1'b0, 16'h00FF, 16'h00FF, 8'h20, 1'b1);
    noise_cycles(2 * PERIOD);

    // Disable mid-period, then disable exactly on a boundary cycle.
    wait_phase(100);
    apply_stimulus(1'b0, 16'h0000, N_OUT'($urandom), 8'($urandom), 1'b1);
    noise_cycles(PERIOD);
    apply_stimulus(1'b0, 16'hFFFF, N_OUT'($urandom), 8'($urandom), 1'b1);
    noise_cycles(PERIOD + 5);
    wait_phase(PERIOD - 1);
    apply_stimulus(1'b0, 16'h0000, N_OUT'($urandom), 8'($urandom), 1'b1);
    noise_cycles(20);

    // Reset in the middle of a period with outputs high.
    apply_stimulus(1'b0, 16'hFFFF, 16'h0000, 8'h00, 1'b1);
    noise_cycles(300);
    apply_stimulus(1'b1, N_OUT'($urandom), N_OUT'($urandom), 8'($urandom), 1'b0);
    noise_cycles(50);

    // Randomized updates, disables and occasional resets.
    for (int k = 0; k < 20; k++) begin
      noise_cycles($urandom_range(20, 1200));
      if ($urandom_range(0, 15) == 0)
        apply_stimulus(1'b1, N_OUT'($urandom), N_OUT'($urandom), 8'($urandom), 1'b0);
      else
        apply_stimulus(1'b0, ($urandom_range(0, 3) == 0) ? 16'h0000 : N_OUT'($urandom),
                       N_OUT'($urandom), 8'($urandom), 1'b1);
    end
    noise_cycles(PERIOD + 10);

    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
